// File: rtl/uart_baud_gen_frac.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen_frac
// Description : Fractional-N baud strobe generator (oversample, mid-bit, bit).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen_frac #(
  parameter int CLOCK_FREQ = 1000000,
  parameter int BAUDRATE   = 1250,
  parameter int OVERSAMPLE = 16,
  parameter int INT_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              div_pending,
  output logic              div_err,
  output logic              tick_os,
  output logic              tick_mid,
  output logic              tick_bit
);

  localparam int              OS_W      = $clog2(OVERSAMPLE);
  localparam longint unsigned DEN       = 64'(BAUDRATE) * 64'(OVERSAMPLE);
  localparam longint unsigned DEF_INT_L = 64'(CLOCK_FREQ) / DEN;
  localparam longint unsigned DEF_FRC_L = ((64'(CLOCK_FREQ) << FRAC_W) / DEN) % (64'(1) << FRAC_W);
  localparam logic [INT_W-1:0]  DEF_INT  = INT_W'(DEF_INT_L);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_FRC_L);
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]   OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [INT_W-1:0]  act_int, sh_int;
  logic [FRAC_W-1:0] act_frac, sh_frac, acc;
  logic              cy;
  logic [INT_W:0]    cnt;
  logic [OS_W-1:0]   os_cnt;

  logic [INT_W:0]    period_last;
  logic              period_end;
  logic [FRAC_W:0]   acc_sum;
  logic              apply;
  logic              load_ok;

  // Period is act_int + cy; act_int >= 2 keeps period_last from underflowing.
  assign period_last = {1'b0, act_int} + {{INT_W{1'b0}}, cy} - {{INT_W{1'b0}}, 1'b1};
  assign period_end  = enable && (cnt == period_last);
  assign acc_sum     = {1'b0, acc} + {1'b0, act_frac};
  assign apply       = div_pending && (!enable || period_end);
  assign load_ok     = div_load && (div_int >= INT_W'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_int     <= DEF_INT;
      act_frac    <= DEF_FRAC;
      sh_int      <= DEF_INT;
      sh_frac     <= DEF_FRAC;
      acc         <= '0;
      cy          <= 1'b0;
      cnt         <= '0;
      os_cnt      <= '0;
      div_pending <= 1'b0;
      div_err     <= 1'b0;
      tick_os     <= 1'b0;
      tick_mid    <= 1'b0;
      tick_bit    <= 1'b0;
    end else begin
      tick_os  <= 1'b0;
      tick_mid <= 1'b0;
      tick_bit <= 1'b0;
      div_err  <= div_load && !load_ok;

      if (!enable) begin
        cnt    <= '0;
        acc    <= '0;
        cy     <= 1'b0;
        os_cnt <= '0;
      end else if (period_end) begin
        cnt       <= '0;
        tick_os   <= 1'b1;
        {cy, acc} <= acc_sum;
        tick_bit  <= (os_cnt == OS_LAST);
        tick_mid  <= (os_cnt == OS_HALF);
        os_cnt    <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
      end else begin
        cnt <= cnt + {{INT_W{1'b0}}, 1'b1};
      end

      // Old shadow applies first; a coincident load refills it and keeps pending set.
      if (apply) begin
        act_int  <= sh_int;
        act_frac <= sh_frac;
      end
      if (load_ok) begin
        sh_int  <= div_int;
        sh_frac <= div_frac;
      end
      div_pending <= load_ok || (div_pending && !apply);
    end
  end

endmodule
`default_nettype wire
